data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles between request acceptance and response (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  CPU request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port req_be  input  4  byte enables; bit i covers wdata[8i+7:8i].
REQ-011 SHALL have port resp_valid  output  1  response present.
REQ-012 SHALL have port resp_ready  input  1  CPU accepts response.
REQ-013 SHALL have port resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 SHALL have port resp_err  output  1  misaligned or out-of-range access.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL assert req_ready only in IDLE; request accepted when req_valid && req_ready at a clock edge.
REQ-017 SHALL register req_we, req_addr, req_wdata, req_be on acceptance; later input changes have no effect.
REQ-018 SHALL transition IDLE->WAIT on acceptance when LATENCY>0, loading a down-counter with LATENCY-1; IDLE->RESP when LATENCY=0.
REQ-019 SHALL transition WAIT->RESP on the edge where the counter is 0, otherwise decrement; resp_valid first asserts exactly LATENCY+1 cycles after the acceptance edge.
REQ-020 SHALL hold resp_valid, resp_rdata, resp_err stable in RESP until resp_valid && resp_ready, then go to IDLE.
REQ-021 SHALL not accept a new request in the cycle the response handshakes (req_ready rises the following cycle).
REQ-022 SHALL flag error when captured addr[1:0]!=0 or word index addr[31:2] >= DEPTH_WORDS.
REQ-023 SHALL commit a store on the WAIT->RESP (or IDLE->RESP) edge, writing only enabled bytes; erroneous stores write nothing.
REQ-024 SHALL return the full word for loads read at the same edge; req_be ignored for loads.
REQ-025 SHALL treat a store with req_be=0 as a non-error no-op with normal response.
REQ-026 SHALL make a store visible to any subsequently accepted load (no stale read).

Reset
REQ-027 SHALL on reset force state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0; req_ready 1 from the first cycle after reset deasserts.
REQ-028 SHALL on reset mid-transaction drop the transaction; an uncommitted store SHALL not be written.
REQ-029 SHALL not clear memory contents on reset.

Structure
REQ-030 SHALL place the FSM state typedef (IDLE/WAIT/RESP), width constants (XLEN=32, BE_W=4) and error-code definitions in shared package rv_mem_pkg.
REQ-031 SHALL instantiate one sub-module dmem_array: DEPTH_WORDS x 32 storage with byte-enable synchronous write and read.
REQ-032 SHALL keep FSM, counter and error checking in data_mem_responder.

Verification
REQ-033 Store 0xDEADBEEF @0x10 be=1111, LATENCY=2, then load @0x10 -> resp_valid 3 cycles after each acceptance, load rdata=0xDEADBEEF, err=0.
REQ-034 Store 0x000000AA @0x10 be=0001 over 0xDEADBEEF -> subsequent load returns 0xDEADBEAA.
REQ-035 Load @0x12 (misaligned) and load @(DEPTH_WORDS*4) -> err=1, rdata=0; store @0x13 -> err=1, memory unchanged.
REQ-036 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid/rdata stable, req_ready=0; after handshake req_ready=1 next cycle.
REQ-037 Assert reset during WAIT of store 0x12345678 @0x20 -> outputs reset values, later load @0x20 returns previous contents.
REQ-038 LATENCY=0 build: back-to-back loads -> resp_valid one cycle after each acceptance, one accepted request every 2 cycles with resp_ready=1.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// ============================================================================
// Module   : rv_mem_pkg
// Purpose  : Shared widths, FSM state encoding and error codes for the data
//            memory responder and its storage array.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_mem_pkg;

    localparam int XLEN  = 32;
    localparam int BE_W  = 4;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2
    } err_code_t;

    // Misalignment takes precedence over range so the reported code is stable.
    function automatic err_code_t addr_check(
        input logic [XLEN-1:0] addr,
        input logic [XLEN-1:0] depth_words
    );
        logic [XLEN-1:0] w_word_idx;
        err_code_t       w_code;
        w_word_idx = {2'b00, addr[XLEN-1:2]};
        w_code     = ERR_NONE;
        if (addr[1:0] != 2'b00) begin
            w_code = ERR_MISALIGN;
        end else if (w_word_idx >= depth_words) begin
            w_code = ERR_RANGE;
        end
        return w_code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// Module   : dmem_array
// Purpose  : Word-organised storage with per-byte synchronous write and a
//            registered read port that holds its value until the next read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_array
    import rv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic [BE_W-1:0]   i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    output logic [XLEN-1:0]   o_rdata
);

    logic [XLEN-1:0] r_mem [DEPTH_WORDS];
    logic [XLEN-1:0] r_rdata;

    // Contents are intentionally never reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Single-outstanding CPU data memory responder with configurable
//            response latency, byte-enabled stores and access error checking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder
    import rv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [BE_W-1:0] req_be,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err
);

    localparam int              c_ADDR_W   = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] c_CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic [XLEN-1:0]  r_addr;
    logic [XLEN-1:0]  r_wdata;
    logic [BE_W-1:0]  r_be;
    logic             r_resp_valid;
    logic             r_resp_err;
    logic             r_rdata_en;

    logic             w_accept;
    logic             w_fire;
    logic             w_cur_we;
    logic [XLEN-1:0]  w_cur_addr;
    logic [XLEN-1:0]  w_cur_wdata;
    logic [BE_W-1:0]  w_cur_be;
    err_code_t        w_err_code;
    logic             w_err;
    logic [BE_W-1:0]  w_mem_we;
    logic             w_mem_re;
    logic [XLEN-1:0]  w_mem_rdata;

    assign w_accept = req_valid && (r_state == IDLE);

    // The memory access happens on the edge that enters RESP: from WAIT when
    // the countdown expires, or straight from IDLE in a zero-latency build.
    assign w_fire = ((r_state == WAIT) && (r_cnt == '0)) ||
                    ((LATENCY == 0) && w_accept);

    // In IDLE the request has not been captured yet, so use the live inputs.
    assign w_cur_we    = (r_state == IDLE) ? req_we    : r_we;
    assign w_cur_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_cur_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
    assign w_cur_be    = (r_state == IDLE) ? req_be    : r_be;

    assign w_err_code = addr_check(w_cur_addr, XLEN'(DEPTH_WORDS));
    assign w_err      = (w_err_code != ERR_NONE);

    // Reset gating keeps a store that is dropped mid-flight out of memory.
    assign w_mem_we = (w_fire && w_cur_we && !w_err && !reset) ? w_cur_be : '0;
    assign w_mem_re = w_fire && !w_cur_we && !w_err && !reset;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (c_ADDR_W)
    ) u_dmem_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (w_cur_addr[c_ADDR_W+1:2]),
        .i_wdata (w_cur_wdata),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rdata_en   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_be    <= req_be;
                        if (LATENCY == 0) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= w_err;
                            r_rdata_en   <= !req_we && !w_err;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= c_CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= w_err;
                        r_rdata_en   <= !r_we && !w_err;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state      <= IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_rdata_en   <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_rdata_en   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    // The array output only changes on a read, so this is stable through RESP.
    assign resp_rdata = r_rdata_en ? w_mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Directed self-checking bench for a LATENCY=2 and a LATENCY=0 build.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DEPTH_WORDS=256, LATENCY=2
    logic        a_reset, a_req_valid, a_req_ready, a_req_we;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic [3:0]  a_req_be;
    logic        a_resp_valid, a_resp_ready, a_resp_err;

    // Instance B: DEPTH_WORDS=16, LATENCY=0
    logic        b_reset, b_req_valid, b_req_ready, b_req_we;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic [3:0]  b_req_be;
    logic        b_resp_valid, b_resp_ready, b_resp_err;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut_a (
        .clk(clk), .reset(a_reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(0)) u_dut_b (
        .clk(clk), .reset(b_reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One complete transaction on instance A; hold = cycles resp_ready stays low in RESP.
    task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, input int hold,
                           input logic [31:0] exp_rd, input logic exp_err);
        int guard;
        int lat;
        guard = 0;
        while (!a_req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        a_req_valid = 1'b1;
        a_req_we    = we;
        a_req_addr  = addr;
        a_req_wdata = wdata;
        a_req_be    = be;
        @(posedge clk); #1;
        // Scramble inputs after acceptance; the captured request must be used.
        a_req_valid = 1'b0;
        a_req_we    = ~we;
        a_req_addr  = 32'h0000_0010;
        a_req_wdata = 32'h5555_5555;
        a_req_be    = 4'hF;
        check({name, "_busy"}, a_req_ready, 1'b0);
        lat = 1;
        while (!a_resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_lat"}, lat, 3);
        for (int k = 0; k < hold; k++) begin
            check({name, "_hold_valid"}, a_resp_valid, 1'b1);
            check({name, "_hold_rdata"}, a_resp_rdata, exp_rd);
            check({name, "_hold_ready"}, a_req_ready, 1'b0);
            @(posedge clk); #1;
        end
        check({name, "_rdata"}, a_resp_rdata, exp_rd);
        check({name, "_err"}, a_resp_err, exp_err);
        a_resp_ready = 1'b1;
        check({name, "_hs_ready"}, a_req_ready, 1'b0);
        @(posedge clk); #1;
        a_resp_ready = 1'b0;
        check({name, "_post_ready"}, a_req_ready, 1'b1);
        check({name, "_post_valid"}, a_resp_valid, 1'b0);
    endtask

    initial begin
        logic [31:0] b_addr [4];
        logic [31:0] b_wdata[4];
        logic        b_we   [4];
        logic [31:0] b_exp  [4];
        int          idx, cyc, last_acc;
        logic        acc;

        vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h10,  32'h000000AA, 4'h1, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
        vecs[4]  = '{1'b0, 32'h12,  32'h0,        4'hF, 32'h0,        1'b1};
        vecs[5]  = '{1'b0, 32'h400, 32'h0,        4'hF, 32'h0,        1'b1};
        vecs[6]  = '{1'b1, 32'h13,  32'h11223344, 4'hF, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
        vecs[8]  = '{1'b1, 32'h10,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
        vecs[10] = '{1'b1, 32'h3FC, 32'h01020304, 4'hF, 32'h0,        1'b0};
        vecs[11] = '{1'b1, 32'h3FC, 32'hCAFEF00D, 4'hC, 32'h0,        1'b0};
        vecs[12] = '{1'b0, 32'h3FC, 32'h0,        4'h0, 32'hCAFE0304, 1'b0};
        vecs[13] = '{1'b1, 32'h20,  32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
        vecs[14] = '{1'b0, 32'h20,  32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};

        a_reset = 1'b1; a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0;
        a_req_wdata = '0; a_req_be = '0; a_resp_ready = 1'b0;
        b_reset = 1'b1; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0;
        b_req_wdata = '0; b_req_be = '0; b_resp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", a_resp_valid, 1'b0);
        check("rst_rdata", a_resp_rdata, 32'h0);
        check("rst_err",   a_resp_err,   1'b0);
        a_reset = 1'b0;
        b_reset = 1'b0;
        check("rst_ready_a", a_req_ready, 1'b1);
        check("rst_ready_b", b_req_ready, 1'b1);

        for (int i = 0; i < NVEC; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].be, 0, vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Backpressure: response held for 5 cycles with resp_ready low.
        run_txn("hold", 1'b0, 32'h10, 32'h0, 4'h0, 5, 32'hDEADBEAA, 1'b0);

        // Reset arrives on the very edge that would commit the store.
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h20;
        a_req_wdata = 32'h12345678; a_req_be = 4'hF;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        @(posedge clk); #1;
        a_reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid", a_resp_valid, 1'b0);
        check("midrst_rdata", a_resp_rdata, 32'h0);
        check("midrst_err",   a_resp_err,   1'b0);
        check("midrst_ready", a_req_ready,  1'b1);
        a_reset = 1'b0;
        @(posedge clk); #1;
        run_txn("midrst_load", 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'hA5A5A5A5, 1'b0);

        // Zero-latency build, back-to-back with resp_ready held high.
        b_addr[0] = 32'h0; b_wdata[0] = 32'h0BADF00D; b_we[0] = 1'b1; b_exp[0] = 32'h0;
        b_addr[1] = 32'h4; b_wdata[1] = 32'h600DCAFE; b_we[1] = 1'b1; b_exp[1] = 32'h0;
        b_addr[2] = 32'h0; b_wdata[2] = 32'h0;        b_we[2] = 1'b0; b_exp[2] = 32'h0BADF00D;
        b_addr[3] = 32'h4; b_wdata[3] = 32'h0;        b_we[3] = 1'b0; b_exp[3] = 32'h600DCAFE;
        idx = 0; cyc = 0; last_acc = -1;
        b_resp_ready = 1'b1;
        b_req_valid  = 1'b1;
        b_req_be     = 4'hF;
        b_req_addr = b_addr[0]; b_req_wdata = b_wdata[0]; b_req_we = b_we[0];
        while (idx < 4 && cyc < 30) begin
            acc = b_req_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                check($sformatf("b%0d_valid", idx), b_resp_valid, 1'b1);
                check($sformatf("b%0d_rdata", idx), b_resp_rdata, b_exp[idx]);
                check($sformatf("b%0d_err", idx), b_resp_err, 1'b0);
                if (last_acc >= 0)
                    check($sformatf("b%0d_spacing", idx), cyc - last_acc, 2);
                last_acc = cyc;
                idx++;
                if (idx < 4) begin
                    b_req_addr = b_addr[idx]; b_req_wdata = b_wdata[idx]; b_req_we = b_we[idx];
                end
            end
        end
        b_req_valid = 1'b0;
        check("b_done", idx, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
